led_pwm_palette_driver: RTL and testbench

Consumes the packed 8-bit palette values produced by the LED palette pulser and converts them into per-LED PWM drive signals for the color (RGB) and basic LEDs. It sits between the palette pulser and the board LED pins. It latches a new palette only at PWM period boundaries, so a value change never produces a glitch within a period. Phase staggering across LED indices spreads the turn-on edges to reduce simultaneous current draw.

---
 rtl/led_pwm_pkg.sv | 17 +
 rtl/clock_enable_divider.sv | 25 ++
 rtl/led_pwm_channel.sv | 32 +++
 rtl/led_pwm_palette_driver.sv | 85 ++++++++
 tb/tb_led_pwm_palette_driver.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM palette driver.
package led_pwm_pkg;

   localparam int c_pwm_bits  = 8;
   localparam int c_pwm_steps = 256;

   // Spreads LED turn-on edges evenly over one PWM period.
   function automatic logic [c_pwm_bits-1:0] phase_offset(input int idx, input int led_count,
                                                          input bit stagger);
      int off;
      off = 0;
      if (stagger && led_count > 0)
         off = (idx * (c_pwm_steps / led_count)) % c_pwm_steps;
      return off[c_pwm_bits-1:0];
   endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// Produces a one-cycle enable every par_ce_divisor cycles of the upstream enable.
module clock_enable_divider #(
   parameter int par_ce_divisor = 1
) (
   input  logic i_clk,
   input  logic i_rst_mhz,
   input  logic i_ce_mhz,
   output logic o_ce
);

   localparam int c_cnt_w = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(par_ce_divisor - 1);

   logic [c_cnt_w-1:0] s_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst_mhz)
         s_cnt <= '0;
      else if (i_ce_mhz)
         s_cnt <= (s_cnt == c_last) ? '0 : s_cnt + 1'b1;
   end

   assign o_ce = i_ce_mhz && (s_cnt == c_last);

endmodule

// File: rtl/led_pwm_channel.sv
// One PWM channel: period-aligned shadow of the duty value, phase add and compare.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter logic [c_pwm_bits-1:0] par_offset = '0
) (
   input  logic                  i_clk,
   input  logic                  i_srst,
   input  logic                  i_load,
   input  logic [c_pwm_bits-1:0] i_value,
   input  logic [c_pwm_bits-1:0] i_count,
   output logic                  o_pwm
);

   logic [c_pwm_bits-1:0] s_shadow;
   logic [c_pwm_bits-1:0] s_phase;

   // Wraps mod 256 through the 8-bit result width.
   assign s_phase = i_count + par_offset;

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         s_shadow <= '0;
         o_pwm    <= 1'b0;
      end else begin
         if (i_load)
            s_shadow <= i_value;
         o_pwm <= (s_phase < s_shadow);
      end
   end

endmodule

// File: rtl/led_pwm_palette_driver.sv
// Converts packed 8-bit palette values into glitch-free, optionally phase-staggered LED PWM.
module led_pwm_palette_driver
   import led_pwm_pkg::*;
#(
   parameter int parm_color_led_count = 4,
   parameter int parm_basic_led_count = 4,
   parameter int parm_FCLK            = 40_000_000,
   parameter int parm_pwm_freq_hz     = 2000,
   parameter int parm_stagger_enable  = 1
) (
   input  logic                              i_clk,
   input  logic                              i_srst,
   input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
   input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
   input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
   input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
   output logic [parm_color_led_count-1:0]   o_color_led_red,
   output logic [parm_color_led_count-1:0]   o_color_led_green,
   output logic [parm_color_led_count-1:0]   o_color_led_blue,
   output logic [parm_basic_led_count-1:0]   o_basic_led,
   output logic                              o_period_start
);

   localparam int c_div_raw = parm_FCLK / (parm_pwm_freq_hz * c_pwm_steps);
   localparam int c_divisor = (c_div_raw < 1) ? 1 : c_div_raw;
   localparam bit c_stagger = (parm_stagger_enable != 0);

   logic                  s_ce;
   logic                  s_wrap;
   logic [c_pwm_bits-1:0] s_pwm_count;

   clock_enable_divider #(
      .par_ce_divisor(c_divisor)
   ) u_ce_div (
      .i_clk    (i_clk),
      .i_rst_mhz(i_srst),
      .i_ce_mhz (1'b1),
      .o_ce     (s_ce)
   );

   // The wrap step is the only instant shadows may change, keeping each period glitch-free.
   assign s_wrap = s_ce && (s_pwm_count == {c_pwm_bits{1'b1}});

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         s_pwm_count    <= '0;
         o_period_start <= 1'b0;
      end else begin
         if (s_ce)
            s_pwm_count <= s_pwm_count + 1'b1;
         o_period_start <= s_wrap;
      end
   end

   for (genvar k = 0; k < parm_color_led_count; k++) begin : g_color
      localparam logic [c_pwm_bits-1:0] c_off = phase_offset(k, parm_color_led_count, c_stagger);

      led_pwm_channel #(.par_offset(c_off)) u_red (
         .i_clk(i_clk), .i_srst(i_srst), .i_load(s_wrap),
         .i_value(i_color_led_red_value[8*k +: 8]), .i_count(s_pwm_count),
         .o_pwm(o_color_led_red[k])
      );
      led_pwm_channel #(.par_offset(c_off)) u_green (
         .i_clk(i_clk), .i_srst(i_srst), .i_load(s_wrap),
         .i_value(i_color_led_green_value[8*k +: 8]), .i_count(s_pwm_count),
         .o_pwm(o_color_led_green[k])
      );
      led_pwm_channel #(.par_offset(c_off)) u_blue (
         .i_clk(i_clk), .i_srst(i_srst), .i_load(s_wrap),
         .i_value(i_color_led_blue_value[8*k +: 8]), .i_count(s_pwm_count),
         .o_pwm(o_color_led_blue[k])
      );
   end

   for (genvar k = 0; k < parm_basic_led_count; k++) begin : g_basic
      localparam logic [c_pwm_bits-1:0] c_off = phase_offset(k, parm_basic_led_count, c_stagger);

      led_pwm_channel #(.par_offset(c_off)) u_lumin (
         .i_clk(i_clk), .i_srst(i_srst), .i_load(s_wrap),
         .i_value(i_basic_led_lumin_value[8*k +: 8]), .i_count(s_pwm_count),
         .o_pwm(o_basic_led[k])
      );
   end

endmodule

// File: tb/tb_led_pwm_palette_driver.sv
// Bench for led_pwm_palette_driver: in-phase and staggered instances against a period-level model.
module tb_led_pwm_palette_driver;

   localparam int NC = 4;
   localparam int NB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       srst;
   logic [7:0] red[NC];
   logic [7:0] grn[NC];
   logic [7:0] blu[NC];
   logic [7:0] bas[NB];
   logic [8*NC-1:0] red_v, grn_v, blu_v;
   logic [8*NB-1:0] bas_v;

   always_comb begin
      red_v = '0; grn_v = '0; blu_v = '0; bas_v = '0;
      for (int k = 0; k < NC; k++) begin
         red_v[8*k +: 8] = red[k];
         grn_v[8*k +: 8] = grn[k];
         blu_v[8*k +: 8] = blu[k];
      end
      for (int k = 0; k < NB; k++) bas_v[8*k +: 8] = bas[k];
   end

   logic [NC-1:0] r0, g0, b0, r1, g1, b1;
   logic [NB-1:0] l0, l1;
   logic          ps0, ps1;
   logic [16:0]   d0, d1;
   assign d0 = {ps0, l0, b0, g0, r0};
   assign d1 = {ps1, l1, b1, g1, r1};

   led_pwm_palette_driver #(
      .parm_color_led_count(NC), .parm_basic_led_count(NB),
      .parm_FCLK(512_000), .parm_pwm_freq_hz(2000), .parm_stagger_enable(0)
   ) dut0 (
      .i_clk(clk), .i_srst(srst),
      .i_color_led_red_value(red_v), .i_color_led_green_value(grn_v),
      .i_color_led_blue_value(blu_v), .i_basic_led_lumin_value(bas_v),
      .o_color_led_red(r0), .o_color_led_green(g0), .o_color_led_blue(b0),
      .o_basic_led(l0), .o_period_start(ps0)
   );

   led_pwm_palette_driver #(
      .parm_color_led_count(NC), .parm_basic_led_count(NB),
      .parm_FCLK(512_000), .parm_pwm_freq_hz(2000), .parm_stagger_enable(1)
   ) dut1 (
      .i_clk(clk), .i_srst(srst),
      .i_color_led_red_value(red_v), .i_color_led_green_value(grn_v),
      .i_color_led_blue_value(blu_v), .i_basic_led_lumin_value(bas_v),
      .o_color_led_red(r1), .o_color_led_green(g1), .o_color_led_blue(b1),
      .o_basic_led(l1), .o_period_start(ps1)
   );

   int errors = 0;
   int checks = 0;

   // Model: channel ch = group*4 + k (red, green, blue, basic); a period is 256 clocks,
   // values latch at the end of each period, and outputs show the previous clock's step.
   int          m_step;
   int          m_duty[16];
   logic [16:0] exp0, exp1;
   bit          started = 0;

   function automatic int input_duty(int ch);
      case (ch / 4)
         0:       return int'(red[ch % 4]);
         1:       return int'(grn[ch % 4]);
         2:       return int'(blu[ch % 4]);
         default: return int'(bas[ch % 4]);
      endcase
   endfunction

   initial begin
      m_step = 0;
      exp0 = '0;
      exp1 = '0;
      for (int ch = 0; ch < 16; ch++) m_duty[ch] = 0;
      forever begin
         @(posedge clk);
         if (srst) begin
            m_step = 0;
            for (int ch = 0; ch < 16; ch++) m_duty[ch] = 0;
            exp0 = '0;
            exp1 = '0;
         end else begin
            for (int ch = 0; ch < 16; ch++) begin
               exp0[ch] = (m_step < m_duty[ch]);
               exp1[ch] = (((m_step + (ch % 4) * 64) % 256) < m_duty[ch]);
            end
            exp0[16] = (m_step == 255);
            exp1[16] = (m_step == 255);
            if (m_step == 255)
               for (int ch = 0; ch < 16; ch++) m_duty[ch] = input_duty(ch);
            m_step = (m_step + 1) % 256;
         end
         started = 1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            checks += 2;
            if (d0 !== exp0) begin
               errors++;
               $display("FAIL model_inphase t=%0t got %h expected %h", $time, d0, exp0);
            end
            if (d1 !== exp1) begin
               errors++;
               $display("FAIL model_stagger t=%0t got %h expected %h", $time, d1, exp1);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_all(input logic [7:0] v);
      for (int k = 0; k < NC; k++) begin red[k] = v; grn[k] = v; blu[k] = v; end
      for (int k = 0; k < NB; k++) bas[k] = v;
   endtask

   task automatic wait_ps(output bit ok);
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (ps0) begin ok = 1; break; end
      end
   endtask

   initial begin
      bit ok;
      int bad, hi_a, hi_b, hi_c, hi_d, hi_e, first_a, last_a, first_d, last_e, low_j, nps, last_ps;
      logic prev_ps;

      srst = 1'b1;
      set_all(8'h00);
      step(3);
      check("reset_outputs_inphase", int'(d0), 0);
      check("reset_outputs_stagger", int'(d1), 0);

      // Full duty: dark for the whole first period, then 255 of 256 steps.
      set_all(8'hFF);
      srst = 1'b0;
      bad = 0;
      for (int j = 1; j <= 256; j++) begin
         step(1);
         if (d0[15:0] != 0 || d1[15:0] != 0) bad++;
      end
      check("dark_first_period", bad, 0);
      check("first_period_start", int'(ps0), 1);
      hi_a = 0; hi_b = 0; low_j = 0;
      for (int j = 1; j <= 256; j++) begin
         step(1);
         if (r0[0]) hi_a++; else low_j = j;
         if (b1[1]) hi_b++;
      end
      check("ff_high_steps", hi_a, 255);
      check("ff_low_at_step255", low_j, 256);
      check("ff_low_with_period_start", int'(ps0), 1);
      check("ff_stagger_high_steps", hi_b, 255);

      // Mixed duties; they take effect from the next period.
      set_all(8'h00);
      red[2] = 8'h80;
      grn[0] = 8'h40;
      blu[0] = 8'h40;
      blu[1] = 8'h40;
      for (int k = 0; k < NB; k++) bas[k] = 8'(k * 48);
      wait_ps(ok);
      check("wait_period_start_a", int'(ok), 1);
      hi_a = 0; hi_b = 0; hi_c = 0; hi_d = 0; hi_e = 0;
      first_a = 0; last_a = 0; first_d = 0; last_e = 0;
      for (int j = 1; j <= 256; j++) begin
         step(1);
         if (j == 100) grn[0] = 8'hC0;
         if (r0[2]) begin hi_a++; if (first_a == 0) first_a = j; last_a = j; end
         if (r0[0]) hi_b++;
         if (g0[0]) hi_c++;
         if (b1[1]) begin hi_d++; if (first_d == 0) first_d = j; end
         if (b1[0]) begin hi_e++; last_e = j; end
      end
      check("red2_half_high", hi_a, 128);
      check("red2_first", first_a, 1);
      check("red2_last", last_a, 128);
      check("red0_off", hi_b, 0);
      check("green0_old_value", hi_c, 64);
      check("stagger_blue1_high", hi_d, 64);
      check("stagger_blue1_first", first_d, 193);
      check("stagger_blue0_high", hi_e, 64);
      check("stagger_blue0_last", last_e, 64);
      hi_c = 0;
      for (int j = 1; j <= 256; j++) begin
         step(1);
         if (g0[0]) hi_c++;
      end
      check("green0_new_value", hi_c, 192);
      check("period_start_after_green", int'(ps0), 1);

      // Reset in mid-period with half duty everywhere.
      set_all(8'h80);
      step(256);
      step(150);
      srst = 1'b1;
      step(1);
      check("midreset_inphase_zero", int'(d0), 0);
      check("midreset_stagger_zero", int'(d1), 0);
      step(1);
      srst = 1'b0;
      nps = 0;
      for (int j = 1; j <= 255; j++) begin
         step(1);
         if (ps0 || ps1) nps++;
      end
      check("no_period_start_after_reset", nps, 0);
      step(1);
      check("period_start_256_after_reset", int'(ps0), 1);

      // Free run: period start spacing.
      nps = 0; bad = 0; last_ps = 0; hi_a = 0;
      prev_ps = 1'b1;
      for (int i = 1; i <= 2600; i++) begin
         step(1);
         if (ps0) begin
            if (prev_ps) hi_a++;
            if (i - last_ps != 256) bad++;
            last_ps = i;
            nps++;
         end
         prev_ps = ps0;
      end
      check("free_run_period_count", nps, 10);
      check("free_run_spacing", bad, 0);
      check("free_run_single_cycle", hi_a, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
